// File: rtl/kernel_kcore_fifo_param_pkg.sv
// rtl/kernel_kcore_fifo_param_pkg.sv - shared constants and clog2 helper for kcore FIFOs
package kernel_kcore_fifo_param_pkg;

   localparam int KCORE_FIFO_DATA_WIDTH = 32;
   localparam int KCORE_FIFO_DEPTH      = 16;

   // Ceiling log2, minimum 1 so a pointer always has at least one bit.
   function automatic int clog2(input int value);
      int res;
      int v;
      res = 0;
      v   = value - 1;
      while (v > 0) begin
         res = res + 1;
         v   = v >>> 1;
      end
      return (res < 1) ? 1 : res;
   endfunction

endpackage

// File: rtl/kernel_kcore_fifo_param_mem.sv
// rtl/kernel_kcore_fifo_param_mem.sv - FIFO storage, sync write / async read, no reset
module kernel_kcore_fifo_param_mem #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 16,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [ADDR_WIDTH-1:0] raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/kernel_kcore_fifo_param.sv
// rtl/kernel_kcore_fifo_param.sv - parametrised show-ahead FIFO with count, thresholds, flush, error
module kernel_kcore_fifo_param
   import kernel_kcore_fifo_param_pkg::*;
#(
   parameter int DATA_WIDTH    = KCORE_FIFO_DATA_WIDTH,
   parameter int DEPTH         = KCORE_FIFO_DEPTH,
   parameter int AFULL_THRESH  = DEPTH - 1,
   parameter int AEMPTY_THRESH = 1,
   localparam int ADDR_WIDTH   = clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   output logic                  if_empty_n,
   input  logic                  if_read_ce,
   input  logic                  if_read,
   output logic [DATA_WIDTH-1:0] if_dout,
   output logic                  if_full_n,
   input  logic                  if_write_ce,
   input  logic                  if_write,
   input  logic [DATA_WIDTH-1:0] if_din,
   input  logic                  if_flush,
   output logic [ADDR_WIDTH:0]   if_count,
   output logic                  if_almost_full_n,
   output logic                  if_almost_empty_n,
   output logic                  if_err
);

   localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);
   localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0]   CNT_AF   = (ADDR_WIDTH + 1)'(AFULL_THRESH);
   localparam logic [ADDR_WIDTH:0]   CNT_AE   = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  empty_n_q, full_n_q, afull_n_q, aempty_n_q;
   logic                  err_q, err_d;
   logic                  wr_acc, rd_acc, err_set;
   logic [DATA_WIDTH-1:0] rdata;

   // Explicit compare-and-wrap so non-power-of-two depths never index past DEPTH-1.
   function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_ONE;
   endfunction

   // Qualified against registered flags: a write while full is dropped even alongside a read.
   assign wr_acc  = if_write & if_write_ce & full_n_q;
   assign rd_acc  = if_read  & if_read_ce  & empty_n_q;
   assign err_set = (if_write & if_write_ce & ~full_n_q) | (if_read & if_read_ce & ~empty_n_q);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      err_d    = err_q | err_set;
      if (wr_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (rd_acc) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
      if (if_flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         err_d    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         empty_n_q  <= 1'b0;
         full_n_q   <= 1'b1;
         afull_n_q  <= (AFULL_THRESH > 0);
         aempty_n_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         empty_n_q  <= (count_d != '0);
         full_n_q   <= (count_d != CNT_FULL);
         afull_n_q  <= !(count_d >= CNT_AF);
         aempty_n_q <= !(count_d <= CNT_AE);
         err_q      <= err_d;
      end
   end

   kernel_kcore_fifo_param_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk     (clk),
      .we_i    (wr_acc & ~if_flush),
      .waddr_i (wr_ptr_q),
      .wdata_i (if_din),
      .raddr_i (rd_ptr_q),
      .rdata_o (rdata)
   );

   assign if_dout           = empty_n_q ? rdata : '0;
   assign if_empty_n        = empty_n_q;
   assign if_full_n         = full_n_q;
   assign if_count          = count_q;
   assign if_almost_full_n  = afull_n_q;
   assign if_almost_empty_n = aempty_n_q;
   assign if_err            = err_q;

endmodule
